// File: rtl/capture_controller.sv
// Write-side controller for the logic-analyzer circular sample buffer.
// Captures pre-trigger and post-trigger samples and reports the trigger and oldest-sample addresses.
module capture_controller #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 4,
    parameter int MEMORY_SIZE = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] probe,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic [ADDR_WIDTH-1:0] pretrig_len,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] data_write,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic [ADDR_WIDTH-1:0] start_addr,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ARMED,
        POST,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEMORY_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] pre_q;
    logic [ADDR_WIDTH-1:0] post_cnt;
    logic                  match;
    logic                  capturing;

    // Mask bits of zero never block the match, so an all-zero mask fires on the first compare.
    assign match     = ((probe ^ trig_value) & trig_mask) == '0;
    assign capturing = (state == FILL) || (state == ARMED) || (state == POST);

    // NOTE: all state and outputs use non-blocking assignments so every register
    // reads the pre-edge values of the others; later assignments in the block override earlier ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wptr         <= '0;
            pre_q        <= '0;
            post_cnt     <= '0;
            write_enable <= 1'b0;
            waddr        <= '0;
            data_write   <= '0;
            trig_addr    <= '0;
            start_addr   <= '0;
            busy         <= 1'b0;
            triggered    <= 1'b0;
            done         <= 1'b0;
        end else if (abort && capturing) begin
            // Trigger and start addresses are deliberately left as they were.
            state        <= IDLE;
            write_enable <= 1'b0;
            busy         <= 1'b0;
            triggered    <= 1'b0;
            done         <= 1'b0;
        end else begin
            if (capturing) begin
                write_enable <= 1'b1;
                waddr        <= wptr;
                data_write   <= probe;
                wptr         <= wptr + ONE;
            end

            case (state)
                IDLE, DONE: begin
                    write_enable <= 1'b0;
                    if (state == DONE) begin
                        done <= 1'b1;
                    end
                    if (arm && !abort) begin
                        pre_q     <= pretrig_len;
                        wptr      <= '0;
                        triggered <= 1'b0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        state     <= (pretrig_len == '0) ? ARMED : FILL;
                    end
                end

                FILL: begin
                    // This edge captures pre-trigger sample number pre_q.
                    if (wptr == pre_q - ONE) begin
                        state <= ARMED;
                    end
                end

                ARMED: begin
                    if (match) begin
                        trig_addr  <= wptr;
                        start_addr <= wptr - pre_q;
                        triggered  <= 1'b1;
                        post_cnt   <= LAST_ADDR - pre_q;
                        if (pre_q == LAST_ADDR) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end else begin
                            state <= POST;
                        end
                    end
                end

                POST: begin
                    post_cnt <= post_cnt - ONE;
                    if (post_cnt == ONE) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state        <= IDLE;
                    write_enable <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

endmodule
